water_level_model: RTL

- Behavioural-synthesizable plant model of the reservoir: the sensor-producing end of the controller's interface.
- Consumes the controller's valve commands (fr1, fr2, fr3, dfr) plus a consumer demand rate, and integrates a water level.
- Drives the thermometer-coded level sensors s[3:1] back to the controller.
- Used for closed-loop simulation and FPGA demo of the reservoir controller.

---
 rtl/water_level_model_pkg.sv | 26 ++
 rtl/water_level_model_if.sv | 29 ++
 rtl/water_level_sensor.sv | 49 ++++
 rtl/water_level_model.sv | 125 ++++++++++++
 4 files changed

// File: rtl/water_level_model_pkg.sv
// Shared reservoir definitions: sensor codes and plant defaults.
// Common to the controller and the level plant model.
package water_reserv_pkg;

    // Thermometer sensor codes as seen by the controller.
    typedef enum logic [2:0] {
        EMPTY = 3'b000,
        LOW   = 3'b001,
        MID   = 3'b011,
        FULL  = 3'b111
    } sens_code_t;

    localparam int DEF_LEVEL_W   = 10;
    localparam int DEF_LEVEL_MAX = 700;
    localparam int DEF_T1        = 100;
    localparam int DEF_T2        = 300;
    localparam int DEF_T3        = 500;
    localparam int DEF_R1        = 2;
    localparam int DEF_R2        = 2;
    localparam int DEF_R3        = 2;
    localparam int DEF_RD        = 1;
    localparam int DEF_DEM_W     = 4;
    localparam int DEF_TICK_DIV  = 4;
    localparam int DEF_HYST      = 8;

endpackage

// File: rtl/water_level_model_if.sv
// Controller <-> plant bundle: valve commands in, sensors out.
// master = controller side, slave = plant model side.
interface water_level_model_if #(
    parameter int LEVEL_W = 10,
    parameter int DEM_W   = 4
);
    logic               fr1;
    logic               fr2;
    logic               fr3;
    logic               dfr;
    logic [DEM_W-1:0]   demand;
    logic               load;
    logic [LEVEL_W-1:0] load_level;
    logic [3:1]         s;
    logic [LEVEL_W-1:0] level;
    logic               tick;
    logic               overflow;
    logic               dry;

    modport master (
        output fr1, fr2, fr3, dfr, demand, load, load_level,
        input  s, level, tick, overflow, dry
    );

    modport slave (
        input  fr1, fr2, fr3, dfr, demand, load, load_level,
        output s, level, tick, overflow, dry
    );
endinterface

// File: rtl/water_level_sensor.sv
// One float switch: threshold compare with optional hold band.
// WATER_MODEL_HYST_EN enables the hysteresis band of HYST units.
module water_level_sensor #(
    parameter int LEVEL_W = 10,
    parameter int T       = 100,
    parameter int HYST    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               plain,
    input  logic [LEVEL_W-1:0] lvl,
    output logic               s
);
`ifdef WATER_MODEL_HYST_EN
    localparam int BAND = HYST;
`else
    localparam int BAND = 0 * HYST;
`endif

    localparam logic [LEVEL_W-1:0] SET_T = LEVEL_W'(T);
    localparam logic [LEVEL_W-1:0] CLR_T = LEVEL_W'(T - BAND);

    logic above;
    logic below;
    logic s_d;

    // Set above threshold, clear below band, otherwise hold.
    // With a zero band the set/clear tests are complementary.
    always_comb begin
        above = (lvl >= SET_T);
        below = (lvl < CLR_T);
        s_d   = s;
        if (plain)
            s_d = above;
        else if (above)
            s_d = 1'b1;
        else if (below)
            s_d = 1'b0;
    end

    // Sensor register moves on the same edge as the level.
    always_ff @(posedge clk) begin
        if (reset)
            s <= 1'b0;
        else if (en)
            s <= s_d;
    end
endmodule

// File: rtl/water_level_model.sv
// Reservoir plant: integrates valve inflow minus demand per tick.
// Optional WATER_MODEL_HYST_EN adds float-switch hysteresis.
module water_level_model
    import water_reserv_pkg::*;
#(
    parameter int LEVEL_W   = DEF_LEVEL_W,
    parameter int LEVEL_MAX = DEF_LEVEL_MAX,
    parameter int T1        = DEF_T1,
    parameter int T2        = DEF_T2,
    parameter int T3        = DEF_T3,
    parameter int R1        = DEF_R1,
    parameter int R2        = DEF_R2,
    parameter int R3        = DEF_R3,
    parameter int RD        = DEF_RD,
    parameter int DEM_W     = DEF_DEM_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int HYST      = DEF_HYST
) (
    input logic           clk,
    input logic           reset,
    water_level_model_if.slave bus
);
    localparam int W2 = LEVEL_W + 2;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0]         LAST  = CW'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0]    MAX_L = LEVEL_W'(LEVEL_MAX);
    localparam logic signed [W2-1:0]  MAX_S = W2'(LEVEL_MAX);
    localparam logic signed [W2-1:0]  R1_S  = W2'(R1);
    localparam logic signed [W2-1:0]  R2_S  = W2'(R2);
    localparam logic signed [W2-1:0]  R3_S  = W2'(R3);
    localparam logic signed [W2-1:0]  RD_S  = W2'(RD);

    logic [CW-1:0]         cnt;
    logic [LEVEL_W-1:0]    level_q;
    logic [LEVEL_W-1:0]    level_d;
    logic                  tick_q;
    logic                  ovf_q;
    logic                  dry_q;
    logic                  tick_cyc;
    logic                  upd;
    logic                  clamp_hi;
    logic                  clamp_lo;
    logic signed [W2-1:0]  inflow;
    logic signed [W2-1:0]  dem_s;
    logic signed [W2-1:0]  raw;

    // Next level: load wins, else integrate on the tick cycle.
    always_comb begin
        tick_cyc = (cnt == LAST);
        inflow   = (bus.fr1 ? R1_S : '0)
                 + (bus.fr2 ? R2_S : '0)
                 + (bus.fr3 ? R3_S : '0)
                 + (bus.dfr ? RD_S : '0);
        dem_s    = W2'(bus.demand);
        raw      = $signed({2'b00, level_q}) + inflow - dem_s;
        clamp_hi = (raw > MAX_S);
        clamp_lo = raw[W2-1];
        upd      = bus.load | tick_cyc;
        level_d  = level_q;
        if (bus.load)
            level_d = (bus.load_level > MAX_L) ? MAX_L : bus.load_level;
        else if (tick_cyc) begin
            if (clamp_hi)
                level_d = MAX_L;
            else if (clamp_lo)
                level_d = '0;
            else
                level_d = raw[LEVEL_W-1:0];
        end
    end

    // Prescaler, level register, tick pulse and sticky clamp flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            level_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dry_q   <= 1'b0;
        end else if (bus.load) begin
            cnt     <= '0;
            level_q <= level_d;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dry_q   <= 1'b0;
        end else begin
            cnt    <= tick_cyc ? '0 : cnt + CW'(1);
            tick_q <= tick_cyc;
            if (tick_cyc) begin
                level_q <= level_d;
                if (clamp_hi)
                    ovf_q <= 1'b1;
                if (clamp_lo)
                    dry_q <= 1'b1;
            end
        end
    end

    water_level_sensor #(
        .LEVEL_W(LEVEL_W), .T(T1), .HYST(HYST)
    ) u_s1 (
        .clk(clk), .reset(reset), .en(upd), .plain(bus.load),
        .lvl(level_d), .s(bus.s[1])
    );

    water_level_sensor #(
        .LEVEL_W(LEVEL_W), .T(T2), .HYST(HYST)
    ) u_s2 (
        .clk(clk), .reset(reset), .en(upd), .plain(bus.load),
        .lvl(level_d), .s(bus.s[2])
    );

    water_level_sensor #(
        .LEVEL_W(LEVEL_W), .T(T3), .HYST(HYST)
    ) u_s3 (
        .clk(clk), .reset(reset), .en(upd), .plain(bus.load),
        .lvl(level_d), .s(bus.s[3])
    );

    assign bus.level    = level_q;
    assign bus.tick     = tick_q;
    assign bus.overflow = ovf_q;
    assign bus.dry      = dry_q;
endmodule
